// File: rtl/corexy_pkg.sv
// ---------------------------------------------------------------------------
// corexy_pkg
//   Shared definitions for the CoreXY step/dir receive decoder.
//   - POS_W_DEFAULT : default width of the signed position counters
//   - PERIOD_W      : width of the step-period measurement
//   - DIR_POS/NEG   : dir pin encoding (0 = positive, 1 = negative); this is
//                     the sign bit of the driver's {dir, magnitude} word
//   - chan_state_e  : per-channel pulse FSM state
//   - sm_to_tc / tc_to_sm : sign-magnitude <-> two's complement conversion,
//                     for comparing decoded positions against driver words
// ---------------------------------------------------------------------------
package corexy_pkg;

  localparam int POS_W_DEFAULT = 32;
  localparam int PERIOD_W      = 32;

  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_HIGH = 1'b1
  } chan_state_e;

  // {sign, magnitude} -> two's complement. Negative zero maps to zero.
  function automatic logic signed [POS_W_DEFAULT-1:0] sm_to_tc(
    input logic [POS_W_DEFAULT-1:0] sm
  );
    logic signed [POS_W_DEFAULT-1:0] mag;
    mag = {1'b0, sm[POS_W_DEFAULT-2:0]};
    return sm[POS_W_DEFAULT-1] ? -mag : mag;
  endfunction

  // Two's complement -> {sign, magnitude}. The most negative value has no
  // sign-magnitude form; the decoder never produces it because positions
  // saturate symmetrically at +/- signed max.
  function automatic logic [POS_W_DEFAULT-1:0] tc_to_sm(
    input logic signed [POS_W_DEFAULT-1:0] tc
  );
    logic signed [POS_W_DEFAULT-1:0] mag;
    mag = tc[POS_W_DEFAULT-1] ? -tc : tc;
    return {tc[POS_W_DEFAULT-1], mag[POS_W_DEFAULT-2:0]};
  endfunction

endpackage

// File: rtl/step_channel_decoder.sv
// ---------------------------------------------------------------------------
// step_channel_decoder
//   One motor channel of the step/dir receiver: synchronizes the asynchronous
//   step and dir pins, tracks each high pulse with a small FSM, checks its
//   width and reports a counted step on the falling edge with the direction
//   that was present at the rising edge.
//
//   Optional feature (macro COREXY_DEC_PERIOD_EN): measures the number of clk
//   cycles between the last two counted steps. Without the macro, period is 0.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   step_pin   in   raw step pin (asynchronous)
//   dir_pin    in   raw dir pin (asynchronous), 0 = +, 1 = -
//   clear      in   zeroes the period measurement (FSM keeps its state)
//   step_valid out  one-cycle pulse: a well-formed step completed
//   step_dir   out  direction of that step, valid with step_valid
//   glitch     out  one-cycle pulse: a high pulse shorter than MIN_HIGH ended
//   dir_chg    out  one-cycle pulse: dir moved while step was high
//   period     out  cycles between the last two counted steps
// ---------------------------------------------------------------------------
module step_channel_decoder
  import corexy_pkg::*;
#(
  parameter int MIN_HIGH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_pin,
  input  logic                dir_pin,
  input  logic                clear,
  output logic                step_valid,
  output logic                step_dir,
  output logic                glitch,
  output logic                dir_chg,
  output logic [PERIOD_W-1:0] period
);

  localparam int            WW        = $clog2(MIN_HIGH + 1);
  localparam logic [WW-1:0] WIDTH_SAT = WW'(MIN_HIGH);
  // The rise cycle itself is one high sample and the counter restarts from 0
  // there, so a pulse with MIN_HIGH high samples ends with MIN_HIGH-1 counted.
  localparam logic [WW-1:0] WIDTH_OK  = WW'(MIN_HIGH - 1);

  // Two flops of synchronization plus one history flop for edge detection.
  logic [2:0]    step_sync;
  logic [2:0]    dir_sync;
  logic          step_s;
  logic          step_q;
  logic          dir_s;
  logic          dir_q;
  logic          rise;
  logic          fall;

  chan_state_e   state;
  logic [WW-1:0] width;
  logic          latched_dir;
  logic          count_now;

  assign step_s = step_sync[1];
  assign step_q = step_sync[2];
  assign dir_s  = dir_sync[1];
  assign dir_q  = dir_sync[2];
  assign rise   = step_s & ~step_q;
  assign fall   = ~step_s & step_q;

  assign count_now = (state == CH_HIGH) && fall && (width >= WIDTH_OK);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would chain the sync stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_sync <= '0;
      dir_sync  <= '0;
    end else begin
      step_sync <= {step_sync[1:0], step_pin};
      dir_sync  <= {dir_sync[1:0], dir_pin};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CH_IDLE;
      width       <= '0;
      latched_dir <= DIR_POS;
      step_valid  <= 1'b0;
      step_dir    <= DIR_POS;
      glitch      <= 1'b0;
      dir_chg     <= 1'b0;
    end else begin
      step_valid <= 1'b0;
      glitch     <= 1'b0;
      dir_chg    <= 1'b0;
      case (state)
        CH_IDLE: begin
          if (rise) begin
            state       <= CH_HIGH;
            width       <= '0;
            latched_dir <= dir_s;
          end
        end
        CH_HIGH: begin
          if (fall) begin
            state <= CH_IDLE;
            if (count_now) begin
              step_valid <= 1'b1;
              step_dir   <= latched_dir;
            end else begin
              glitch <= 1'b1;
            end
          end else begin
            if (width != WIDTH_SAT) width <= width + WW'(1);
            if (dir_s != dir_q) dir_chg <= 1'b1;
          end
        end
        default: state <= CH_IDLE;
      endcase
    end
  end

`ifdef COREXY_DEC_PERIOD_EN
  localparam logic [PERIOD_W-1:0] PERIOD_SAT = '1;

  // Free-running gap counter; restarts at 1 on each counted step so the value
  // captured at the next step equals the number of cycles between them.
  // It sits saturated after reset/clear, so the first step reports PERIOD_SAT.
  logic [PERIOD_W-1:0] period_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      period_cnt <= PERIOD_SAT;
      period     <= '0;
    end else if (count_now) begin
      period     <= period_cnt;
      period_cnt <= PERIOD_W'(1);
    end else if (period_cnt != PERIOD_SAT) begin
      period_cnt <= period_cnt + PERIOD_W'(1);
    end
  end
`else
  logic unused_clear;
  assign unused_clear = clear;
  assign period       = '0;
`endif

endmodule

// File: rtl/corexy_step_decoder.sv
// ---------------------------------------------------------------------------
// corexy_step_decoder
//   Position monitor on the receive side of a CoreXY step/dir interface.
//   Decodes both motor pulse trains into signed motor positions A/B and the
//   Cartesian positions X = (A+B)>>>1, Y = (A-B)>>>1. Flags malformed pulses
//   and counter saturation with sticky error bits.
//
//   Optional feature (macro COREXY_DEC_PERIOD_EN): per-channel step period
//   measurement on period_a/period_b; otherwise those ports read 0.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   step_in_1, dir_in_1    motor A step/dir pins (asynchronous), dir 0 = +
//   step_in_2, dir_in_2    motor B step/dir pins (asynchronous)
//   clear                  zero positions, sticky flags and periods
//   pos_a, pos_b           signed motor positions (update 3 clk after pin fall)
//   pos_x, pos_y           signed Cartesian positions (4 clk after pin fall)
//   half_step              A+B odd: X/Y are truncated by half a step
//   moving                 a step was counted within IDLE_TIMEOUT cycles
//   glitch_err             sticky: a pulse shorter than MIN_HIGH was seen
//   dir_err                sticky: dir changed while step was high
//   ovf_err                sticky: a position counter saturated
//   period_a, period_b     cycles between the last two counted steps
// ---------------------------------------------------------------------------
module corexy_step_decoder
  import corexy_pkg::*;
#(
  parameter int POS_W        = POS_W_DEFAULT,
  parameter int MIN_HIGH     = 4,
  parameter int IDLE_TIMEOUT = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_in_1,
  input  logic                    dir_in_1,
  input  logic                    step_in_2,
  input  logic                    dir_in_2,
  input  logic                    clear,
  output logic signed [POS_W-1:0] pos_a,
  output logic signed [POS_W-1:0] pos_b,
  output logic signed [POS_W-1:0] pos_x,
  output logic signed [POS_W-1:0] pos_y,
  output logic                    half_step,
  output logic                    moving,
  output logic                    glitch_err,
  output logic                    dir_err,
  output logic                    ovf_err,
  output logic [PERIOD_W-1:0]     period_a,
  output logic [PERIOD_W-1:0]     period_b
);

  localparam logic [POS_W-1:0] POS_ONE     = POS_W'(1);
  localparam logic [POS_W-1:0] POS_MAX     = {1'b0, {(POS_W-1){1'b1}}};
  // Symmetric negative limit (-POS_MAX) keeps every position representable
  // in the driver's sign-magnitude form.
  localparam logic [POS_W-1:0] POS_NEG_LIM = ~POS_MAX + POS_ONE;

  localparam int            IW        = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  logic valid_a, dir_a, glitch_a, dchg_a;
  logic valid_b, dir_b, glitch_b, dchg_b;

  step_channel_decoder #(.MIN_HIGH(MIN_HIGH)) u_chan_a (
    .clk        (clk),
    .rst        (rst),
    .step_pin   (step_in_1),
    .dir_pin    (dir_in_1),
    .clear      (clear),
    .step_valid (valid_a),
    .step_dir   (dir_a),
    .glitch     (glitch_a),
    .dir_chg    (dchg_a),
    .period     (period_a)
  );

  step_channel_decoder #(.MIN_HIGH(MIN_HIGH)) u_chan_b (
    .clk        (clk),
    .rst        (rst),
    .step_pin   (step_in_2),
    .dir_pin    (dir_in_2),
    .clear      (clear),
    .step_valid (valid_b),
    .step_dir   (dir_b),
    .glitch     (glitch_b),
    .dir_chg    (dchg_b),
    .period     (period_b)
  );

  // Returns {saturated, next_position} for one optional +/-1 step.
  function automatic logic [POS_W:0] step_pos(
    input logic [POS_W-1:0] pos,
    input logic             valid,
    input logic             dir
  );
    logic [POS_W:0] r;
    r = {1'b0, pos};
    if (valid) begin
      if (dir == DIR_POS) begin
        if (pos == POS_MAX) r[POS_W] = 1'b1;
        else                r[POS_W-1:0] = pos + POS_ONE;
      end else begin
        if (pos == POS_NEG_LIM) r[POS_W] = 1'b1;
        else                    r[POS_W-1:0] = pos - POS_ONE;
      end
    end
    return r;
  endfunction

  logic [POS_W-1:0]    next_a;
  logic [POS_W-1:0]    next_b;
  logic                ovf_a;
  logic                ovf_b;
  logic signed [POS_W:0] sum_ab;
  logic signed [POS_W:0] diff_ab;
  logic                unused_diff_lsb;

  // NOTE: every always_comb output gets a value on every path (here via the
  // function's default) so no latch is inferred.
  always_comb begin
    {ovf_a, next_a} = step_pos(pos_a, valid_a, dir_a);
    {ovf_b, next_b} = step_pos(pos_b, valid_b, dir_b);
    // POS_W+1 bits hold A+B and A-B without wrap.
    sum_ab  = $signed({pos_a[POS_W-1], pos_a}) + $signed({pos_b[POS_W-1], pos_b});
    diff_ab = $signed({pos_a[POS_W-1], pos_a}) - $signed({pos_b[POS_W-1], pos_b});
  end

  // A-B has the same parity as A+B, so only the sum's LSB drives half_step.
  assign unused_diff_lsb = diff_ab[0];

  logic          step_seen;
  logic [IW-1:0] idle_cnt;

  // A step landing in the clear cycle is dropped, so it does not count.
  assign step_seen = (valid_a | valid_b) & ~clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_a      <= '0;
      pos_b      <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      half_step  <= 1'b0;
      glitch_err <= 1'b0;
      dir_err    <= 1'b0;
      ovf_err    <= 1'b0;
    end else if (clear) begin
      pos_a      <= '0;
      pos_b      <= '0;
      pos_x      <= '0;
      pos_y      <= '0;
      half_step  <= 1'b0;
      glitch_err <= 1'b0;
      dir_err    <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      pos_a      <= next_a;
      pos_b      <= next_b;
      // Slicing [POS_W:1] of the wide value is the arithmetic shift right by
      // one, truncated back to POS_W (the result always fits).
      pos_x      <= sum_ab[POS_W:1];
      pos_y      <= diff_ab[POS_W:1];
      half_step  <= sum_ab[0];
      glitch_err <= glitch_err | glitch_a | glitch_b;
      dir_err    <= dir_err | dchg_a | dchg_b;
      ovf_err    <= ovf_err | ovf_a | ovf_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      moving   <= 1'b0;
      idle_cnt <= '0;
    end else if (step_seen) begin
      moving   <= 1'b1;
      idle_cnt <= '0;
    end else if (moving) begin
      if (idle_cnt == IDLE_LAST) begin
        moving   <= 1'b0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_corexy_step_decoder.sv
module tb_corexy_step_decoder;

  logic clk = 1'b0;
  logic rst;
  logic step_in_1, dir_in_1, step_in_2, dir_in_2, clear;
  logic signed [31:0] pos_a, pos_b, pos_x, pos_y;
  logic half_step, moving, glitch_err, dir_err, ovf_err;
  logic [31:0] period_a, period_b;

  // Narrow instance used only for the saturation scenario.
  logic s_step, s_dir;
  logic signed [7:0] s_pos_a, s_pos_b, s_pos_x, s_pos_y;
  logic s_half, s_moving, s_glitch, s_dir_err, s_ovf;
  logic [31:0] s_period_a, s_period_b;

  int errors = 0;
  int checks = 0;

`ifdef COREXY_DEC_PERIOD_EN
  localparam logic [31:0] PERIOD_FIRST  = 32'hFFFF_FFFF;
  localparam logic [31:0] PERIOD_STEADY = 32'd100;
`else
  localparam logic [31:0] PERIOD_FIRST  = 32'd0;
  localparam logic [31:0] PERIOD_STEADY = 32'd0;
`endif

  always #5 clk = ~clk;

  corexy_step_decoder u_dut (
    .clk(clk), .rst(rst),
    .step_in_1(step_in_1), .dir_in_1(dir_in_1),
    .step_in_2(step_in_2), .dir_in_2(dir_in_2),
    .clear(clear),
    .pos_a(pos_a), .pos_b(pos_b), .pos_x(pos_x), .pos_y(pos_y),
    .half_step(half_step), .moving(moving),
    .glitch_err(glitch_err), .dir_err(dir_err), .ovf_err(ovf_err),
    .period_a(period_a), .period_b(period_b)
  );

  corexy_step_decoder #(.POS_W(8)) u_dut_small (
    .clk(clk), .rst(rst),
    .step_in_1(s_step), .dir_in_1(s_dir),
    .step_in_2(1'b0), .dir_in_2(1'b0),
    .clear(1'b0),
    .pos_a(s_pos_a), .pos_b(s_pos_b), .pos_x(s_pos_x), .pos_y(s_pos_y),
    .half_step(s_half), .moving(s_moving),
    .glitch_err(s_glitch), .dir_err(s_dir_err), .ovf_err(s_ovf),
    .period_a(s_period_a), .period_b(s_period_b)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_a(input logic d, input int hi, input int lo);
    dir_in_1 = d; step_in_1 = 1'b1; tick(hi);
    step_in_1 = 1'b0; tick(lo);
  endtask

  task automatic pulse_both(input logic da, input logic db, input int hi, input int lo);
    dir_in_1 = da; dir_in_2 = db; step_in_1 = 1'b1; step_in_2 = 1'b1; tick(hi);
    step_in_1 = 1'b0; step_in_2 = 1'b0; tick(lo);
  endtask

  task automatic pulse_s(input logic d, input int hi, input int lo);
    s_dir = d; s_step = 1'b1; tick(hi);
    s_step = 1'b0; tick(lo);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(1);
    clear = 1'b0; tick(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(5);
    checks++; if (pos_a !== 32'sd0 || pos_b !== 32'sd0) begin errors++; $display("FAIL reset_pos_ab: got a=%0d b=%0d, want 0 0", pos_a, pos_b); end
    checks++; if (pos_x !== 32'sd0 || pos_y !== 32'sd0) begin errors++; $display("FAIL reset_pos_xy: got x=%0d y=%0d, want 0 0", pos_x, pos_y); end
    checks++; if ({half_step, moving, glitch_err, dir_err, ovf_err} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b, want 00000", {half_step, moving, glitch_err, dir_err, ovf_err}); end
    checks++; if (period_a !== 32'd0 || period_b !== 32'd0) begin errors++; $display("FAIL reset_period: got %0h %0h, want 0 0", period_a, period_b); end
    rst = 1'b0; tick(2);
  endtask

  task automatic test_single_axis();
    do_clear();
    for (int i = 0; i < 10; i++) pulse_a(1'b0, 8, 8);
    checks++; if (pos_a !== 32'sd10 || pos_b !== 32'sd0) begin errors++; $display("FAIL t1_pos_ab: got a=%0d b=%0d, want 10 0", pos_a, pos_b); end
    checks++; if (pos_x !== 32'sd5 || pos_y !== 32'sd5) begin errors++; $display("FAIL t1_pos_xy: got x=%0d y=%0d, want 5 5", pos_x, pos_y); end
    checks++; if (moving !== 1'b1 || half_step !== 1'b0) begin errors++; $display("FAIL t1_moving: got moving=%b half=%b, want 1 0", moving, half_step); end
    tick(990);
    checks++; if (moving !== 1'b1) begin errors++; $display("FAIL t1_moving_before_timeout: got %b, want 1", moving); end
    tick(10);
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL t1_moving_after_timeout: got %b, want 0", moving); end
  endtask

  task automatic test_both_axes();
    do_clear();
    for (int i = 0; i < 7; i++) pulse_both(1'b0, 1'b1, 8, 8);
    tick(2);
    checks++; if (pos_a !== 32'sd7 || pos_b !== -32'sd7) begin errors++; $display("FAIL t2_pos_ab: got a=%0d b=%0d, want 7 -7", pos_a, pos_b); end
    checks++; if (pos_x !== 32'sd0 || pos_y !== 32'sd7) begin errors++; $display("FAIL t2_pos_xy: got x=%0d y=%0d, want 0 7", pos_x, pos_y); end
    checks++; if (half_step !== 1'b0) begin errors++; $display("FAIL t2_half: got %b, want 0", half_step); end
    dir_in_2 = 1'b0;
  endtask

  task automatic test_half_step();
    do_clear();
    for (int i = 0; i < 3; i++) pulse_a(1'b0, 8, 8);
    checks++; if (pos_a !== 32'sd3 || pos_b !== 32'sd0) begin errors++; $display("FAIL t3_pos_ab: got a=%0d b=%0d, want 3 0", pos_a, pos_b); end
    checks++; if (pos_x !== 32'sd1 || pos_y !== 32'sd1) begin errors++; $display("FAIL t3_pos_xy: got x=%0d y=%0d, want 1 1", pos_x, pos_y); end
    checks++; if (half_step !== 1'b1) begin errors++; $display("FAIL t3_half: got %b, want 1", half_step); end
  endtask

  task automatic test_min_width();
    do_clear();
    pulse_a(1'b0, 2, 8);
    checks++; if (pos_a !== 32'sd0 || glitch_err !== 1'b1) begin errors++; $display("FAIL t4_glitch2: got a=%0d glitch=%b, want 0 1", pos_a, glitch_err); end
    do_clear();
    checks++; if (glitch_err !== 1'b0) begin errors++; $display("FAIL t4_clear_glitch: got %b, want 0", glitch_err); end
    pulse_a(1'b0, 4, 8);
    checks++; if (pos_a !== 32'sd1 || glitch_err !== 1'b0) begin errors++; $display("FAIL t4_width4: got a=%0d glitch=%b, want 1 0", pos_a, glitch_err); end
    pulse_a(1'b0, 3, 8);
    checks++; if (pos_a !== 32'sd1 || glitch_err !== 1'b1) begin errors++; $display("FAIL t4_width3: got a=%0d glitch=%b, want 1 1", pos_a, glitch_err); end
  endtask

  task automatic test_dir_change();
    do_clear();
    checks++; if (dir_err !== 1'b0) begin errors++; $display("FAIL t5_dir_err_clear: got %b, want 0", dir_err); end
    dir_in_1 = 1'b0; step_in_1 = 1'b1; tick(3);
    dir_in_1 = 1'b1; tick(5);
    step_in_1 = 1'b0; tick(8);
    dir_in_1 = 1'b0; tick(4);
    checks++; if (pos_a !== 32'sd1 || dir_err !== 1'b1) begin errors++; $display("FAIL t5_dir_a: got a=%0d dir_err=%b, want 1 1", pos_a, dir_err); end
    do_clear();
    dir_in_2 = 1'b1; step_in_2 = 1'b1; tick(3);
    dir_in_2 = 1'b0; tick(5);
    step_in_2 = 1'b0; tick(8);
    checks++; if (pos_b !== -32'sd1 || dir_err !== 1'b1) begin errors++; $display("FAIL t5_dir_b: got b=%0d dir_err=%b, want -1 1", pos_b, dir_err); end
  endtask

  task automatic test_latency();
    do_clear();
    dir_in_1 = 1'b0; step_in_1 = 1'b1; tick(8);
    step_in_1 = 1'b0; tick(3);
    checks++; if (pos_a !== 32'sd0 || half_step !== 1'b0) begin errors++; $display("FAIL lat_t2: got a=%0d half=%b, want 0 0", pos_a, half_step); end
    tick(1);
    checks++; if (pos_a !== 32'sd1 || half_step !== 1'b0) begin errors++; $display("FAIL lat_t3: got a=%0d half=%b, want 1 0", pos_a, half_step); end
    tick(1);
    checks++; if (half_step !== 1'b1 || pos_x !== 32'sd0 || pos_y !== 32'sd0) begin errors++; $display("FAIL lat_t4: got half=%b x=%0d y=%0d, want 1 0 0", half_step, pos_x, pos_y); end
    tick(4);
  endtask

  task automatic test_clear_collision();
    do_clear();
    pulse_a(1'b0, 8, 8);
    pulse_a(1'b0, 8, 8);
    dir_in_1 = 1'b0; step_in_1 = 1'b1; tick(8);
    step_in_1 = 1'b0; tick(3);
    clear = 1'b1; tick(1);
    clear = 1'b0; tick(6);
    checks++; if (pos_a !== 32'sd0) begin errors++; $display("FAIL clear_wins: got a=%0d, want 0", pos_a); end
  endtask

  task automatic test_period();
    do_clear();
    pulse_a(1'b0, 8, 92);
    checks++; if (period_a !== PERIOD_FIRST) begin errors++; $display("FAIL period_first: got %0h, want %0h", period_a, PERIOD_FIRST); end
    pulse_a(1'b0, 8, 92);
    pulse_a(1'b0, 8, 92);
    checks++; if (period_a !== PERIOD_STEADY) begin errors++; $display("FAIL period_steady: got %0d, want %0d", period_a, PERIOD_STEADY); end
    checks++; if (period_b !== 32'd0) begin errors++; $display("FAIL period_b_idle: got %0h, want 0", period_b); end
  endtask

  task automatic test_reset_mid_pulse();
    dir_in_1 = 1'b0; step_in_1 = 1'b1; tick(6);
    rst = 1'b1; tick(3);
    rst = 1'b0; tick(8);
    step_in_1 = 1'b0; tick(8);
    checks++; if (pos_a !== 32'sd1 || glitch_err !== 1'b0) begin errors++; $display("FAIL rst_mid_pulse: got a=%0d glitch=%b, want 1 0", pos_a, glitch_err); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 127; i++) pulse_s(1'b0, 4, 4);
    tick(4);
    checks++; if (s_pos_a !== 8'sd127 || s_ovf !== 1'b0) begin errors++; $display("FAIL ovf_preload: got a=%0d ovf=%b, want 127 0", s_pos_a, s_ovf); end
    checks++; if (s_pos_x !== 8'sd63 || s_half !== 1'b1) begin errors++; $display("FAIL ovf_preload_x: got x=%0d half=%b, want 63 1", s_pos_x, s_half); end
    pulse_s(1'b0, 4, 4);
    tick(4);
    checks++; if (s_pos_a !== 8'sd127 || s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_saturate: got a=%0d ovf=%b, want 127 1", s_pos_a, s_ovf); end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0;
    step_in_1 = 1'b0; dir_in_1 = 1'b0; step_in_2 = 1'b0; dir_in_2 = 1'b0;
    s_step = 1'b0; s_dir = 1'b0;
    test_reset();
    test_single_axis();
    test_both_axes();
    test_half_step();
    test_min_width();
    test_dir_change();
    test_latency();
    test_clear_collision();
    test_period();
    test_reset_mid_pulse();
    test_overflow();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
